// File: rtl/reg_xfer_ctrl.sv
// reg_xfer_ctrl: command-driven master for the 4x8 register group.
// Accepts one register-transfer command per handshake, reads both operands
// through the group's sr/dr ports, computes the result and writes it back
// to the destination register. Four cycles per command.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   cmd_valid/ready     command handshake (ready only while idle)
//   cmd_op/sr/dr/imm    opcode, source index, destination index, immediate
//   rf_sr/rf_dr         register group read/write indices
//   rf_we/rf_i          register group write enable and write data
//   rf_s/rf_d           register group read data (contents of rf_sr/rf_dr)
//   done                one-cycle completion pulse
//   result              last computed result, held until the next EXEC
//   flag_z/flag_c       zero flag, carry (ADD) / borrow (SUB, CMP) flag
module reg_xfer_ctrl #(
  parameter int unsigned DW = 8,
  parameter int unsigned RW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic [RW-1:0] cmd_sr,
  input  logic [RW-1:0] cmd_dr,
  input  logic [DW-1:0] cmd_imm,
  output logic [RW-1:0] rf_sr,
  output logic [RW-1:0] rf_dr,
  output logic          rf_we,
  output logic [DW-1:0] rf_i,
  input  logic [DW-1:0] rf_s,
  input  logic [DW-1:0] rf_d,
  output logic          done,
  output logic [DW-1:0] result,
  output logic          flag_z,
  output logic          flag_c
);

  localparam int unsigned OPW = 3;

  localparam logic [OPW-1:0] OP_MOV = 3'b000;
  localparam logic [OPW-1:0] OP_ADD = 3'b001;
  localparam logic [OPW-1:0] OP_SUB = 3'b010;
  localparam logic [OPW-1:0] OP_AND = 3'b011;
  localparam logic [OPW-1:0] OP_OR  = 3'b100;
  localparam logic [OPW-1:0] OP_NOT = 3'b101;
  localparam logic [OPW-1:0] OP_LDI = 3'b110;
  localparam logic [OPW-1:0] OP_CMP = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_EXEC  = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [OPW-1:0] op_q;
  logic [DW-1:0]  imm_q;
  logic [DW-1:0]  opa_q;   // source operand s
  logic [DW-1:0]  opb_q;   // destination operand d

  logic           accept;
  logic           cmd_ready_d;
  logic           rf_we_d;
  logic           done_d;
  logic [DW-1:0]  rf_i_d;

  logic [DW:0]    sum;
  logic [DW:0]    diff;
  logic [DW-1:0]  alu_res;
  logic           alu_c;
  logic           alu_z;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: only IDLE waits on an input
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (cmd_valid) state_d = S_READ;
      S_READ:  state_d = S_EXEC;
      S_EXEC:  state_d = S_WRITE;
      S_WRITE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: next values of the registered handshake/write outputs
  always_comb begin
    accept      = 1'b0;
    cmd_ready_d = 1'b0;
    rf_we_d     = 1'b0;
    done_d      = 1'b0;
    rf_i_d      = '0;
    if (state_q == S_IDLE) begin
      accept = cmd_valid;
    end
    if (state_d == S_IDLE) begin
      cmd_ready_d = 1'b1;
    end
    // WRITE is only ever entered from EXEC, so the ALU output is current here
    if (state_d == S_WRITE) begin
      done_d  = 1'b1;
      rf_i_d  = alu_res;
      rf_we_d = (op_q != OP_CMP);
    end
  end

  // ALU on the latched operands; borrow is the top bit of the widened difference
  always_comb begin
    sum     = {1'b0, opb_q} + {1'b0, opa_q};
    diff    = {1'b0, opb_q} - {1'b0, opa_q};
    alu_res = '0;
    alu_c   = 1'b0;
    case (op_q)
      OP_MOV: alu_res = opa_q;
      OP_ADD: begin
        alu_res = sum[DW-1:0];
        alu_c   = sum[DW];
      end
      OP_SUB, OP_CMP: begin
        alu_res = diff[DW-1:0];
        alu_c   = diff[DW];
      end
      OP_AND: alu_res = opb_q & opa_q;
      OP_OR:  alu_res = opb_q | opa_q;
      OP_NOT: alu_res = ~opa_q;
      OP_LDI: alu_res = imm_q;
      default: alu_res = '0;
    endcase
    alu_z = (alu_res == '0);
  end

  // Handshake and write-port outputs; async reset drops rf_we at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_ready <= 1'b1;
      rf_we     <= 1'b0;
      done      <= 1'b0;
      rf_i      <= '0;
    end else begin
      cmd_ready <= cmd_ready_d;
      rf_we     <= rf_we_d;
      done      <= done_d;
      rf_i      <= rf_i_d;
    end
  end

  // Command latch; indices stay on rf_sr/rf_dr until the next accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q  <= '0;
      imm_q <= '0;
      rf_sr <= '0;
      rf_dr <= '0;
    end else if (accept) begin
      op_q  <= cmd_op;
      imm_q <= cmd_imm;
      rf_sr <= cmd_sr;
      rf_dr <= cmd_dr;
    end
  end

  // Operand capture at the end of READ
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa_q <= '0;
      opb_q <= '0;
    end else if (state_q == S_READ) begin
      opa_q <= rf_s;
      opb_q <= rf_d;
    end
  end

  // Result and flags, updated only at the end of EXEC
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= '0;
      flag_z <= 1'b0;
      flag_c <= 1'b0;
    end else if (state_q == S_EXEC) begin
      result <= alu_res;
      flag_z <= alu_z;
      flag_c <= alu_c;
    end
  end

endmodule
